// File: rtl/csr_tmr_irq.sv
// csr_tmr_irq: machine timer with NCMP compare channels.
// Each channel is one-shot or periodic auto-reload. Pending bits are
// sticky and cleared by writing 1. A fixed-priority encoder produces
// the timer interrupt and its channel ID for the trap unit.
// Optional macro CSR_TMR_SNAPSHOT_EN: a read of MTIME lo latches the
// upper mtime bits, so a following read of MTIME hi is coherent.
module csr_tmr_irq #(
  parameter int          NCMP      = 2,
  parameter int          TIMER_W   = 64,
  parameter int          PSC_W     = 8,
  parameter logic [11:0] ADDR_BASE = 12'hBC0,
  localparam int         IDW       = (NCMP > 1) ? $clog2(NCMP) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             csr_we_i,
  input  logic [11:0]      csr_addr_i,
  input  logic [31:0]      csr_wdata_i,
  output logic [31:0]      csr_rdata_o,
  input  logic             hx_valid,
  output logic             irq_o,
  output logic [IDW-1:0]   irq_id_o,
  output logic [NCMP-1:0]  hit_o
);

  localparam int HI_W = TIMER_W - 32;

  logic [11:0]        off;
  logic               in_win;
  logic               wr;
  logic [TIMER_W-1:0] mtime;
  logic [HI_W-1:0]    mtime_hi;
  logic [PSC_W-1:0]   psc_cnt;
  logic [PSC_W-1:0]   psc;
  logic               run;
  logic               tick;
  logic [NCMP-1:0]    pend;
  logic [NCMP-1:0]    ien;
  logic [NCMP-1:0]    mode;
  logic [NCMP-1:0]    hit;
  logic [NCMP-1:0]    reload;
  logic [NCMP-1:0]    clr_mask;
  logic [NCMP-1:0]    active;
  logic [IDW-1:0]     id_nxt;
  logic [TIMER_W-1:0] cmp [NCMP];
  logic [31:0]        per [NCMP];

  assign off      = csr_addr_i - ADDR_BASE;
  assign in_win   = (off < 12'd40);
  assign wr       = csr_we_i & in_win;
  assign tick     = run && (psc_cnt == psc);
  assign clr_mask = (wr && off == 12'd3) ? csr_wdata_i[NCMP-1:0] : '0;
  assign hit_o    = hit;

  // Per-channel compare hit and periodic-reload qualification
  always_comb begin
    hit    = '0;
    reload = '0;
    for (int i = 0; i < NCMP; i++) begin
      hit[i]    = (mtime >= cmp[i]);
      reload[i] = hit[i] & mode[i] & (per[i] != 32'd0);
    end
  end

  // Timebase: prescaler counter and mtime, software writes beat ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime   <= '0;
      psc_cnt <= '0;
    end else begin
      if (wr && off == 12'd0)
        mtime[31:0] <= csr_wdata_i;
      else if (wr && off == 12'd1)
        mtime[TIMER_W-1:32] <= csr_wdata_i[HI_W-1:0];
      else if (tick)
        mtime <= mtime + TIMER_W'(1);

      if (wr && off == 12'd2)
        psc_cnt <= '0;
      else if (tick)
        psc_cnt <= '0;
      else if (run)
        psc_cnt <= psc_cnt + PSC_W'(1);
    end
  end

  // Control, enable and mode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= 1'b0;
      psc  <= '0;
      ien  <= '0;
      mode <= '0;
    end else if (wr) begin
      if (off == 12'd2) begin
        run <= csr_wdata_i[0];
        psc <= csr_wdata_i[8 +: PSC_W];
      end
      if (off == 12'd4) ien  <= csr_wdata_i[NCMP-1:0];
      if (off == 12'd5) mode <= csr_wdata_i[NCMP-1:0];
    end
  end

  // Sticky pending bits: a hit in the same cycle as a clear keeps the bit set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~clr_mask) | hit;
  end

  // Compare and period registers; a software compare write drops a reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCMP; i++) begin
        cmp[i] <= '1;
        per[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCMP; i++) begin
        if (wr && off == 12'(8 + 4 * i))
          cmp[i][31:0] <= csr_wdata_i;
        else if (wr && off == 12'(9 + 4 * i))
          cmp[i][TIMER_W-1:32] <= csr_wdata_i[HI_W-1:0];
        else if (reload[i])
          cmp[i] <= cmp[i] + TIMER_W'(per[i]);
        if (wr && off == 12'(10 + 4 * i))
          per[i] <= csr_wdata_i;
      end
    end
  end

  // Lowest-index pending and enabled channel wins
  always_comb begin
    active = pend & ien;
    id_nxt = '0;
    for (int i = NCMP - 1; i >= 0; i--) begin
      if (active[i]) id_nxt = IDW'(i);
    end
  end

  // Interrupt outputs only move on retiring instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_o    <= 1'b0;
      irq_id_o <= '0;
    end else if (hx_valid) begin
      irq_o    <= |active;
      irq_id_o <= id_nxt;
    end
  end

`ifdef CSR_TMR_SNAPSHOT_EN
  logic [HI_W-1:0] shadow;

  // Capture the upper word on any access to MTIME lo
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              shadow <= '0;
    else if (off == 12'd0)   shadow <= mtime[TIMER_W-1:32];
  end

  assign mtime_hi = shadow;
`else
  assign mtime_hi = mtime[TIMER_W-1:32];
`endif

  // Combinational read mux over the CSR window
  always_comb begin
    csr_rdata_o = '0;
    if (in_win) begin
      case (off)
        12'd0:   csr_rdata_o = mtime[31:0];
        12'd1:   csr_rdata_o = 32'(mtime_hi);
        12'd2:   csr_rdata_o = 32'(run) | (32'(psc) << 8);
        12'd3:   csr_rdata_o = 32'(pend);
        12'd4:   csr_rdata_o = 32'(ien);
        12'd5:   csr_rdata_o = 32'(mode);
        default: csr_rdata_o = '0;
      endcase
      for (int i = 0; i < NCMP; i++) begin
        if (off == 12'(8 + 4 * i))  csr_rdata_o = cmp[i][31:0];
        if (off == 12'(9 + 4 * i))  csr_rdata_o = 32'(cmp[i][TIMER_W-1:32]);
        if (off == 12'(10 + 4 * i)) csr_rdata_o = per[i];
      end
    end
  end

endmodule

// File: tb/tb_csr_tmr_irq.sv
// tb_csr_tmr_irq: directed bench for csr_tmr_irq (default parameters).
// A cycle-level reference model runs beside the DUT and a compare process
// checks every output on each falling edge; directed scenarios add
// hand-computed literal expectations.
module tb_csr_tmr_irq;

  localparam logic [11:0] BASE = 12'hBC0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        csr_we_i = 1'b0;
  logic [11:0] csr_addr_i = BASE + 12'd7;
  logic [31:0] csr_wdata_i = '0;
  logic [31:0] csr_rdata_o;
  logic        hx_valid = 1'b1;
  logic        irq_o;
  logic [0:0]  irq_id_o;
  logic [1:0]  hit_o;

  int checks = 0;
  int errors = 0;

  csr_tmr_irq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_we_i    (csr_we_i),
    .csr_addr_i  (csr_addr_i),
    .csr_wdata_i (csr_wdata_i),
    .csr_rdata_o (csr_rdata_o),
    .hx_valid    (hx_valid),
    .irq_o       (irq_o),
    .irq_id_o    (irq_id_o),
    .hit_o       (hit_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  longint unsigned m_mtime;
  longint unsigned m_cmp [2];
  int unsigned     m_per [2];
  int unsigned     m_psc_cnt, m_psc;
  bit              m_run;
  bit [1:0]        m_pend, m_ien, m_mode;
  bit              m_irq;
  int              m_id;
`ifdef CSR_TMR_SNAPSHOT_EN
  int unsigned     m_shadow;
`endif

  function automatic bit [1:0] modelHit();
    return {m_mtime >= m_cmp[1], m_mtime >= m_cmp[0]};
  endfunction

  function automatic logic [31:0] mread(logic [11:0] a);
    int o;
    o = int'(a) - int'(BASE);
    case (o)
      0:  return 32'(m_mtime);
`ifdef CSR_TMR_SNAPSHOT_EN
      1:  return m_shadow;
`else
      1:  return 32'(m_mtime >> 32);
`endif
      2:  return (m_psc << 8) | 32'(m_run);
      3:  return 32'(m_pend);
      4:  return 32'(m_ien);
      5:  return 32'(m_mode);
      8:  return 32'(m_cmp[0]);
      9:  return 32'(m_cmp[0] >> 32);
      10: return m_per[0];
      12: return 32'(m_cmp[1]);
      13: return 32'(m_cmp[1] >> 32);
      14: return m_per[1];
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    m_mtime = 0; m_psc_cnt = 0; m_psc = 0; m_run = 0;
    m_pend = 0; m_ien = 0; m_mode = 0; m_irq = 0; m_id = 0;
    for (int i = 0; i < 2; i++) begin
      m_cmp[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      m_per[i] = 0;
    end
`ifdef CSR_TMR_SNAPSHOT_EN
    m_shadow = 0;
`endif
  endtask

  task automatic modelStep();
    int       o;
    bit       wr, tk;
    bit [1:0] h, act, clr;
    o   = int'(csr_addr_i) - int'(BASE);
    wr  = csr_we_i && (o >= 0) && (o < 40);
    tk  = m_run && (m_psc_cnt == m_psc);
    h   = modelHit();
    act = m_pend & m_ien;
    if (hx_valid) begin
      m_irq = |act;
      m_id  = act[0] ? 0 : (act[1] ? 1 : 0);
    end
`ifdef CSR_TMR_SNAPSHOT_EN
    if (o == 0) m_shadow = 32'(m_mtime >> 32);
`endif
    clr    = (wr && o == 3) ? csr_wdata_i[1:0] : 2'b00;
    m_pend = (m_pend & ~clr) | h;
    for (int i = 0; i < 2; i++) begin
      if (wr && o == 8 + 4 * i)
        m_cmp[i] = {32'(m_cmp[i] >> 32), csr_wdata_i};
      else if (wr && o == 9 + 4 * i)
        m_cmp[i] = {csr_wdata_i, 32'(m_cmp[i])};
      else if (h[i] && m_mode[i] && m_per[i] != 0)
        m_cmp[i] = m_cmp[i] + longint'(m_per[i]);
      if (wr && o == 10 + 4 * i) m_per[i] = csr_wdata_i;
    end
    if (wr && o == 0)      m_mtime = {32'(m_mtime >> 32), csr_wdata_i};
    else if (wr && o == 1) m_mtime = {csr_wdata_i, 32'(m_mtime)};
    else if (tk)           m_mtime = m_mtime + 1;
    if (wr && o == 2)      m_psc_cnt = 0;
    else if (m_run)        m_psc_cnt = tk ? 0 : m_psc_cnt + 1;
    if (wr && o == 2) begin
      m_run = csr_wdata_i[0];
      m_psc = {24'd0, csr_wdata_i[15:8]};
    end
    if (wr && o == 4) m_ien  = csr_wdata_i[1:0];
    if (wr && o == 5) m_mode = csr_wdata_i[1:0];
  endtask

  // Advance the reference model alongside the DUT registers
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else        modelStep();
  end

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare every DUT output to the model on each falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("hit_o", 64'(hit_o), 64'(modelHit()));
      checkOutput("irq_o", 64'(irq_o), 64'(m_irq));
      checkOutput("irq_id_o", 64'(irq_id_o), 64'(m_id));
      checkOutput("csr_rdata_o", 64'(csr_rdata_o), 64'(mread(csr_addr_i)));
    end
  end

  task automatic applyReset();
    @(negedge clk); #1;
    rst_n = 1'b0; csr_we_i = 1'b0; hx_valid = 1'b1; csr_addr_i = BASE + 12'd7;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One CSR write, landing on the next rising edge
  task automatic applyStimulus(input int o, input logic [31:0] d);
    @(negedge clk); #1;
    csr_we_i = 1'b1; csr_addr_i = BASE + 12'(o); csr_wdata_i = d;
    @(negedge clk); #1;
    csr_we_i = 1'b0; csr_addr_i = BASE + 12'd7;
  endtask

  task automatic readCsr(input int o, output logic [31:0] d);
    @(negedge clk); #1;
    csr_we_i = 1'b0; csr_addr_i = BASE + 12'(o);
    #1 d = csr_rdata_o;
  endtask

  task automatic waitIrq(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (irq_o) seen = 1'b1;
    end
    checkOutput({name, " irq timeout"}, 64'(seen), 64'd1);
  endtask

  logic [31:0] rd;
  bit          found;

  initial begin
    #1 rst_n = 1'b0;
    applyReset();

    // Reset values and window boundaries
    readCsr(0, rd);  checkOutput("rst mtime lo", 64'(rd), 64'h0);
    readCsr(1, rd);  checkOutput("rst mtime hi", 64'(rd), 64'h0);
    readCsr(8, rd);  checkOutput("rst cmp0 lo", 64'(rd), 64'hFFFFFFFF);
    readCsr(9, rd);  checkOutput("rst cmp0 hi", 64'(rd), 64'hFFFFFFFF);
    readCsr(13, rd); checkOutput("rst cmp1 hi", 64'(rd), 64'hFFFFFFFF);
    readCsr(3, rd);  checkOutput("rst pend", 64'(rd), 64'h0);
    checkOutput("rst irq_o", 64'(irq_o), 64'h0);
    checkOutput("rst irq_id_o", 64'(irq_id_o), 64'h0);
    applyStimulus(16, 32'h1234);
    readCsr(16, rd); checkOutput("chan2 ignored", 64'(rd), 64'h0);
    readCsr(6, rd);  checkOutput("unused off", 64'(rd), 64'h0);
    readCsr(-1, rd); checkOutput("below window", 64'(rd), 64'h0);
    readCsr(40, rd); checkOutput("above window", 64'(rd), 64'h0);

    // Prescaler: PSC=3 ticks every fourth cycle
    $display("[TB] prescaler");
    applyStimulus(2, 32'h0000_0301);
    repeat (40) @(negedge clk);
    applyStimulus(2, 32'h0);
    readCsr(0, rd);  checkOutput("psc mtime", 64'(rd), 64'd10);
    repeat (10) @(negedge clk);
    readCsr(0, rd);  checkOutput("psc frozen", 64'(rd), 64'd10);

    // One-shot on channel 1
    $display("[TB] one-shot");
    applyReset();
    applyStimulus(12, 32'd5);
    applyStimulus(13, 32'd0);
    applyStimulus(4, 32'd2);
    applyStimulus(2, 32'd1);
    @(negedge clk); #1 csr_addr_i = BASE;
    waitIrq("oneshot");
    checkOutput("oneshot mtime at irq", 64'(csr_rdata_o), 64'd7);
    checkOutput("oneshot irq_id", 64'(irq_id_o), 64'd1);
    checkOutput("oneshot hit", 64'(hit_o), 64'b10);
    applyStimulus(3, 32'd2);
    readCsr(3, rd);  checkOutput("oneshot w1c held", 64'(rd), 64'd2);

    // Periodic reload on channel 0
    $display("[TB] periodic");
    applyReset();
    applyStimulus(5, 32'd1);
    applyStimulus(10, 32'd10);
    applyStimulus(9, 32'd0);
    applyStimulus(8, 32'd10);
    applyStimulus(2, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1 csr_addr_i = BASE + 12'd3;
      found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
        @(negedge clk);
        if (csr_rdata_o[0]) found = 1'b1;
      end
      checkOutput("periodic pend seen", 64'(found), 64'd1);
      applyStimulus(3, 32'd1);
      readCsr(8, rd);
      checkOutput("periodic cmp0", 64'(rd), 64'(10 + 10 * k));
    end

    // Priority encoding and hx_valid gating
    $display("[TB] priority");
    applyReset();
    applyStimulus(9, 32'd0);
    applyStimulus(8, 32'd3);
    applyStimulus(13, 32'd0);
    applyStimulus(12, 32'd3);
    applyStimulus(4, 32'd3);
    applyStimulus(2, 32'd1);
    waitIrq("prio");
    checkOutput("prio irq_id", 64'(irq_id_o), 64'd0);
    readCsr(3, rd);  checkOutput("prio pend", 64'(rd), 64'd3);
    @(negedge clk); #1 hx_valid = 1'b0;
    applyStimulus(8, 32'hFFFF_FFFF);
    applyStimulus(12, 32'hFFFF_FFFF);
    applyStimulus(3, 32'd3);
    readCsr(3, rd);  checkOutput("gate pend cleared", 64'(rd), 64'd0);
    checkOutput("gate irq held", 64'(irq_o), 64'd1);
    @(negedge clk); #1 hx_valid = 1'b1;
    @(negedge clk); #1 hx_valid = 1'b0;
    checkOutput("gate irq dropped", 64'(irq_o), 64'd0);
    hx_valid = 1'b1;

    // Software compare write collides with a periodic reload
    $display("[TB] collision");
    applyReset();
    applyStimulus(5, 32'd1);
    applyStimulus(10, 32'd4);
    applyStimulus(9, 32'd0);
    applyStimulus(8, 32'd2);
    applyStimulus(2, 32'd1);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (hit_o[0]) begin
        #1;
        csr_we_i = 1'b1; csr_addr_i = BASE + 12'd8; csr_wdata_i = 32'h100;
        @(negedge clk); #1;
        csr_we_i = 1'b0; csr_addr_i = BASE + 12'd7;
        found = 1'b1;
      end
    end
    checkOutput("collision hit seen", 64'(found), 64'd1);
    readCsr(8, rd);  checkOutput("collision cmp0", 64'(rd), 64'h100);

    // Carry across the lo word while reading lo then hi
    $display("[TB] carry read");
    applyReset();
    applyStimulus(0, 32'hFFFF_FFFF);
    readCsr(0, rd);  checkOutput("carry lo", 64'(rd), 64'hFFFFFFFF);
    applyStimulus(2, 32'd1);
    repeat (2) @(negedge clk);
    readCsr(1, rd);
`ifdef CSR_TMR_SNAPSHOT_EN
    checkOutput("carry hi snapshot", 64'(rd), 64'd0);
`else
    checkOutput("carry hi live", 64'(rd), 64'd1);
`endif
    readCsr(0, rd);
    readCsr(1, rd);  checkOutput("carry hi after", 64'(rd), 64'd1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/csr_tmr_irq.md
Name: csr_tmr_irq

Overview:
Parametrised machine timer and interrupt-source block with NCMP independent compare channels. Each channel runs in one-shot or periodic auto-reload mode. It has a prescaled timebase, sticky write-1-to-clear pending bits, per-channel enables and a fixed-priority encoder. The block sits beside the core CSR file on the same idex CSR access channel and feeds one masked timer interrupt plus a channel ID to the trap unit.

Parameters:
NCMP, 2, number of compare channels; legal range 1..8.
TIMER_W, 64, mtime/compare width; legal range 33..64; bits above TIMER_W read 0.
PSC_W, 8, prescaler width.
ADDR_BASE, 12'hBC0, base CSR address of the 40-entry window.
IDW (localparam), max(1, clog2(NCMP)), width of the channel ID.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
csr_we_i  in  1  CSR write enable (idex channel)
csr_addr_i  in  12  CSR address
csr_wdata_i  in  32  write data; takes effect at the clock edge
csr_rdata_o  out  32  read data; combinational; 0 outside the window
hx_valid  in  1  instruction retire strobe; gates the interrupt output update
irq_o  out  1  masked timer interrupt request
irq_id_o  out  IDW  lowest-index pending and enabled channel
hit_o  out  NCMP  raw compare-hit vector (debug/trace)

Behaviour:
- Address map, offsets from ADDR_BASE:
  - +0 MTIME[31:0]
  - +1 MTIME[TIMER_W-1:32]
  - +2 CTRL: bit0 RUN; [8+PSC_W-1:8] PSC
  - +3 PEND, write-1-to-clear
  - +4 IEN
  - +5 MODE, 1 = periodic
  - +8+4i CMPi lo; +9+4i CMPi hi; +10+4i PERi (32-bit)
  - Unused offsets and channels i >= NCMP read 0; writes to them are ignored.
- Reset values:
  - mtime 0, psc_cnt 0, CTRL 0, PEND 0, IEN 0, MODE 0.
  - Every CMPi all-ones; every PERi 0.
  - irq_o 0, irq_id_o 0.
- Prescaler:
  - When RUN=1, psc_cnt increments each cycle.
  - When psc_cnt==PSC: tick for one cycle, psc_cnt<=0, mtime<=mtime+1 (wraps modulo 2^TIMER_W).
  - PSC=0 gives a tick every cycle.
  - RUN=0 freezes psc_cnt and mtime. Writing CTRL clears psc_cnt.
- Compare:
  - hit[i] = (mtime >= CMPi), unsigned, evaluated every cycle.
  - hit_o = hit; it is combinational from registers.
- Pending:
  - PEND[i] <= 1 in every cycle that hit[i]=1, regardless of IEN.
  - Writing 1 clears PEND[i]. If hit[i] persists into the next cycle, the bit re-sets.
  - A write-1-to-clear in the same cycle as a set: the set wins.
- Periodic mode (MODE[i]=1 and PERi != 0):
  - In any cycle with hit[i]=1, CMPi <= CMPi + PERi, truncated to TIMER_W.
  - This yields exactly one PEND set per period.
  - MODE[i]=1 with PERi=0 behaves as one-shot.
- Write priority:
  - A software write to CMPi lo/hi in the same cycle as a reload: the software write wins; the reload is dropped.
  - A software write to MTIME in the same cycle as a tick: the write wins.
- Interrupt output:
  - On every clk edge with hx_valid=1: irq_o <= |(PEND & IEN); irq_id_o <= lowest i with PEND[i]&IEN[i], or 0 if none.
  - With hx_valid=0, both hold their values.
  - Latency: one edge after the PEND set, given hx_valid=1.
- Reads are combinational from current register state; a write is visible to reads on the cycle after it.
- Reset asserted mid-count returns all state to the reset values immediately (asynchronous).

Optional Feature:
CSR_TMR_SNAPSHOT_EN:
- Defined: reading MTIME lo (csr_we_i=0, addr=+0) latches the upper mtime bits into a shadow register; reading +1 returns the shadow. The shadow resets to 0 and is also loaded by writes to +0. This gives a coherent 64-bit read across a lo-word carry.
- Undefined: +1 returns the live upper bits and the shadow register is not built.

Test Plan:
- Reset values: after reset, read the whole window -> MTIME=0, CMP0 lo/hi=FFFFFFFF/FFFFFFFF, PEND=0; irq_o=0 and irq_id_o=0.
- Prescaler: write CTRL=0x0301 (PSC=3, RUN=1), run 40 cycles -> MTIME=10; with RUN=0, MTIME stays at 10.
- One-shot: write CMP1 lo=5, hi=0, IEN=2, RUN=1 with PSC=0 and hx_valid held at 1 -> PEND[1] sets when mtime reaches 5; irq_o=1 and irq_id_o=1 on the next edge. W1C of 2 does not clear PEND while hit persists.
- Periodic: MODE=1, CMP0=10, PER0=10 -> PEND[0] sets at mtime 10, 20 and 30. Clear it each time via W1C; CMP0 reads 40 after the third hit.
- Priority and gating: channels 0 and 1 both pending, IEN=3 -> irq_id_o=0. Hold hx_valid=0 while clearing PEND -> irq_o holds 1 until hx_valid pulses.
- Collision and snapshot: write CMP0 in the same cycle as a periodic reload -> the written value survives. With CSR_TMR_SNAPSHOT_EN, mtime=0x0_FFFFFFFF, read lo then hi -> hi=0 even though mtime carried to 0x1_00000000.
